npc_exec_sequencer: RTL

Multi-cycle control FSM for the NPC core. It fetches an instruction and presents its decode pattern to the instruction lookup table. It then uses the returned micro command to sequence execute, data-memory access and writeback, and to update the PC. It owns the PC, the instruction latch, the retired-instruction counter and the halt state. It sits between the instruction/data memory ports, the decoder, the ALU and the register file.

---
 rtl/npc_exec_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/npc_exec_sequencer.sv
// Multi-cycle control sequencer for the NPC core: fetch, decode lookup, execute,
// data-memory access and writeback, plus ownership of pc/inst/instret/halt state.
module npc_exec_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          PATTERN_LEN = 15,
    parameter int          MICRO_LEN   = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic [PATTERN_LEN-1:0] dec_pattern,
    input  logic [MICRO_LEN-1:0]   dec_micro,
    input  logic                   dec_hit,
    output logic [MICRO_LEN-1:0]   micro,
    input  logic                   branch_cond,
    input  logic [31:0]            jump_target,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [1:0]             dmem_size,
    input  logic                   dmem_ack,
    output logic                   rf_we,
    output logic [31:0]            pc,
    output logic [31:0]            inst,
    output logic [31:0]            instret,
    output logic                   halted,
    output logic                   illegal
);

    // state   | meaning
    // FETCH   | imem request outstanding, latch inst on ack
    // DECODE  | decoder looks at inst, micro latched
    // EXEC    | ALU operands settle
    // MEM     | dmem request outstanding until ack
    // WB      | register write, retire, pc update
    // HALT    | stopped, left only through rst
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0]  IMM_I  = 3'd1;
    localparam logic [2:0]  IMM_SB = 3'd3;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [2:0]  state;
    logic        run;
    logic        regen;
    logic        pcjen;
    logic [1:0]  mwen;
    logic [1:0]  mren;
    logic [2:0]  imm_type;
    logic        taken;
    logic [31:0] pc_next;

    assign regen    = micro[13];
    assign pcjen    = micro[12];
    assign mwen     = micro[10:9];
    assign mren     = micro[8:7];
    assign imm_type = micro[2:0];

    always_comb begin
        taken   = pcjen & ((imm_type != IMM_SB) | branch_cond);
        pc_next = pc + 32'd4;
        if (taken) begin
            pc_next = {jump_target[31:1], (imm_type == IMM_I) ? 1'b0 : jump_target[0]};
        end
    end

    // run holds off the first fetch until the first edge after reset release
    assign imem_req    = (state == S_FETCH) & run;
    assign imem_addr   = pc;
    assign dmem_req    = (state == S_MEM);
    assign dmem_we     = (state == S_MEM) & (|mwen);
    assign dmem_size   = (state != S_MEM) ? 2'b00 : ((|mwen) ? mwen : mren);
    assign rf_we       = (state == S_WB) & regen;
    assign dec_pattern = {inst[31:25], inst[14:12], inst[6:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            inst    <= 32'd0;
            micro   <= '0;
            instret <= 32'd0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (run && imem_ack) begin
                        inst  <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    micro <= dec_micro;
                    if (inst == EBREAK) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (!dec_hit) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if ((|mren) || (|mwen)) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc      <= pc_next;
                    instret <= instret + 32'd1;
                    // a misaligned target still retires, then stops the core
                    if (pc_next[1]) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
